// File: rtl/vlx_byte_combiner.sv
// Merges single-byte stores into word writes through a combining buffer and word FIFO drained by a Wishbone classic master.
// Byte ack lands one cycle after accept; bytes stall while flush is pending or a needed FIFO push has no room.
module vlx_byte_combiner #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        byte_stb_i,
    input  logic [31:0] byte_adr_i,
    input  logic [7:0]  byte_dat_i,
    output logic        byte_ack_o,
    input  logic        flush_i,
    output logic        busy_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_dat_o,
    input  logic        wb_ack_i
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [29:0] wa;
        logic [3:0]  sel;
        logic [31:0] dat;
    } entry_t;

    typedef enum logic [1:0] {IDLE, WRITE, GAP} state_t;

    logic        buf_vld;
    logic [29:0] buf_wa;
    logic [3:0]  buf_sel;
    logic [31:0] buf_dat;
    logic        flush_pend;

    entry_t      mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    state_t      state;

    logic [3:0]  lane_bit;
    logic [31:0] lane_dat;
    logic        hit;
    logic        byte_req;
    logic        fifo_full;
    logic        pop;
    logic        space;
    logic        accept;
    logic        push;
    entry_t      push_entry;
    entry_t      head;

    // Big-endian lanes: address offset 0 lands in the top byte.
    assign lane_bit   = 4'b1000 >> byte_adr_i[1:0];
    assign lane_dat   = {byte_dat_i, 24'h0} >> {byte_adr_i[1:0], 3'b000};
    assign hit        = buf_vld && (byte_adr_i[31:2] == buf_wa) && ((buf_sel & lane_bit) == 4'h0);
    assign byte_req   = byte_stb_i && !byte_ack_o && !flush_pend;
    assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
    assign pop        = (state == WRITE) && wb_ack_i;
    // A pop in the same cycle frees the slot the push needs.
    assign space      = !fifo_full || pop;
    assign accept     = byte_req && (!buf_vld || hit || space);
    assign push       = buf_vld && space && ((buf_sel == 4'hF) || flush_pend || (byte_req && !hit));
    assign push_entry = {buf_wa, buf_sel, buf_dat};
    assign head       = mem[rd_ptr];
    assign busy_o     = buf_vld || (count != '0) || (state != IDLE) || flush_pend;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            buf_vld    <= 1'b0;
            buf_wa     <= '0;
            buf_sel    <= '0;
            buf_dat    <= '0;
            flush_pend <= 1'b0;
            byte_ack_o <= 1'b0;
        end else begin
            byte_ack_o <= accept;
            if (accept) begin
                if (!buf_vld || push) begin
                    buf_vld <= 1'b1;
                    buf_wa  <= byte_adr_i[31:2];
                    buf_sel <= lane_bit;
                    buf_dat <= lane_dat;
                end else begin
                    buf_sel <= buf_sel | lane_bit;
                    buf_dat <= buf_dat | lane_dat;
                end
            end else if (push) begin
                buf_vld <= 1'b0;
            end
            if (flush_i) begin
                flush_pend <= 1'b1;
            end else if (flush_pend && (!buf_vld || push)) begin
                flush_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // The head entry stays in the FIFO until acked, so the bus holds its own copy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_adr_o <= '0;
            wb_sel_o <= '0;
            wb_dat_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (count != '0) begin
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        wb_we_o  <= 1'b1;
                        wb_adr_o <= {head.wa, 2'b00};
                        wb_sel_o <= head.sel;
                        wb_dat_o <= head.dat;
                        state    <= WRITE;
                    end
                end
                WRITE: begin
                    if (wb_ack_i) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_we_o  <= 1'b0;
                        state    <= GAP;
                    end
                end
                GAP:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vlx_byte_combiner.sv
// Bench for vlx_byte_combiner: directed scenarios plus random byte streams scored against a word-level reference model.
module tb_vlx_byte_combiner;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        byte_stb_i = 1'b0;
    logic [31:0] byte_adr_i = '0;
    logic [7:0]  byte_dat_i = '0;
    logic        byte_ack_o;
    logic        flush_i = 1'b0;
    logic        busy_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_adr_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_o;
    logic        wb_ack_i = 1'b0;

    int checks = 0;
    int errors = 0;
    logic ack_block = 1'b0;
    logic ack_nowait = 1'b1;

    logic [65:0] got_q[$];
    logic [65:0] exp_q[$];

    // Reference model: bytes gathered per word, emitted as one write per word run.
    logic        m_vld = 1'b0;
    logic [29:0] m_wa = '0;
    logic [7:0]  m_byte [4];
    logic [3:0]  m_have = '0;

    vlx_byte_combiner #(.FIFO_DEPTH(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .byte_stb_i(byte_stb_i), .byte_adr_i(byte_adr_i), .byte_dat_i(byte_dat_i),
        .byte_ack_o(byte_ack_o), .flush_i(flush_i), .busy_o(busy_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
        .wb_ack_i(wb_ack_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Wishbone slave: optional random wait states, or held off entirely.
    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            wb_ack_i = 1'b0;
            if (wb_cyc_o && wb_stb_o && !ack_block && (ack_nowait || $urandom_range(0, 2) == 0))
                wb_ack_i = 1'b1;
        end
    end

    always @(negedge clk_i) begin
        if (rst_ni && wb_cyc_o && wb_stb_o && wb_ack_i) begin
            checks++;
            if ({wb_we_o, wb_adr_o[1:0]} !== 3'b100) begin
                errors++;
                $display("FAIL bus_write_ctl: we/adr[1:0] got %b want 100", {wb_we_o, wb_adr_o[1:0]});
            end
            got_q.push_back({wb_adr_o[31:2], wb_sel_o, wb_dat_o});
        end
    end

    function automatic void model_emit();
        logic [3:0]  s;
        logic [31:0] d;
        s = '0;
        d = '0;
        if (!m_vld) return;
        for (int l = 0; l < 4; l++) begin
            if (m_have[l]) begin
                s[3-l] = 1'b1;
                d[31-8*l -: 8] = m_byte[l];
            end
        end
        exp_q.push_back({m_wa, s, d});
        m_vld = 1'b0;
    endfunction

    function automatic void model_byte(input logic [31:0] a, input logic [7:0] d);
        logic [1:0] l;
        l = a[1:0];
        if (m_vld && (a[31:2] != m_wa || m_have[l])) model_emit();
        if (!m_vld) begin
            m_vld  = 1'b1;
            m_wa   = a[31:2];
            m_have = '0;
        end
        m_have[l] = 1'b1;
        m_byte[l] = d;
        if (m_have == 4'hF) model_emit();
    endfunction

    task automatic clear_state();
        got_q.delete();
        exp_q.delete();
        m_vld = 1'b0;
    endtask

    task automatic apply_reset();
        rst_ni = 1'b0;
        byte_stb_i = 1'b0;
        flush_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        clear_state();
    endtask

    // Called one time unit after a rising edge; returns at the same phase.
    task automatic send_byte(input logic [31:0] a, input logic [7:0] d, output bit ok);
        ok = 1'b0;
        byte_adr_i = a;
        byte_dat_i = d;
        byte_stb_i = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk_i);
            #1;
            if (byte_ack_o) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL byte_ack_timeout: adr %h got no ack, want ack within 200 cycles", a);
            byte_stb_i = 1'b0;
            return;
        end
        model_byte(a, d);
        @(posedge clk_i);
        #1;
        byte_stb_i = 1'b0;
        checks++;
        if (byte_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL byte_ack_width: ack got %b in second cycle want 0", byte_ack_o);
        end
    endtask

    task automatic flush_pulse();
        flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        model_emit();
    endtask

    task automatic drain(input int budget, input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk_i);
            #1;
            if (!busy_o) begin
                done = 1'b1;
                break;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_drain: busy_o got 1 after %0d cycles want 0", name, budget);
        end
    endtask

    task automatic test_reset();
        bit ok;
        bit seen;
        checks++;
        if ({byte_ack_o, busy_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o} !== '0) begin
            errors++;
            $display("FAIL reset_state: outputs got %h want 0",
                     {byte_ack_o, busy_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o});
        end
        ack_block = 1'b1;
        send_byte(32'h3000_0001, 8'h77, ok);
        flush_pulse();
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk_i);
            #1;
            if (wb_cyc_o) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL reset_setup: wb_cyc_o got 0 want 1 before reset");
        end
        @(posedge clk_i);
        #3;
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({byte_ack_o, busy_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o} !== '0) begin
            errors++;
            $display("FAIL reset_async: outputs got %h want 0",
                     {byte_ack_o, busy_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o});
        end
        ack_block = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        clear_state();
        repeat (10) @(posedge clk_i);
        #1;
        checks++;
        if ({busy_o, wb_cyc_o} !== 2'b00 || got_q.size() != 0) begin
            errors++;
            $display("FAIL reset_after: busy/cyc got %b writes %0d want 00 and 0 writes",
                     {busy_o, wb_cyc_o}, got_q.size());
        end
    endtask

    task automatic test_full_word();
        bit ok;
        logic [31:0] b;
        logic [7:0]  v [4];
        b = 32'h0383C1D0;
        v = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        clear_state();
        for (int i = 0; i < 4; i++) send_byte(b + 32'(i), v[i], ok);
        drain(100, "full_word");
        checks++;
        if (got_q.size() != 1 || got_q[0] !== {b[31:2], 4'hF, 32'hAABBCCDD}) begin
            errors++;
            $display("FAIL full_word: got %0d writes first %h want 1 write %h",
                     got_q.size(), got_q.size() > 0 ? got_q[0] : 66'h0, {b[31:2], 4'hF, 32'hAABBCCDD});
        end
    endtask

    task automatic test_partial_flush();
        bit ok;
        logic [31:0] b;
        logic [31:0] b4;
        b = 32'h0383C1D0;
        b4 = b + 32'd4;
        clear_state();
        send_byte(b + 32'd2, 8'h11, ok);
        send_byte(b + 32'd5, 8'h22, ok);
        repeat (20) @(posedge clk_i);
        #1;
        checks++;
        if (got_q.size() != 1 || got_q[0] !== {b[31:2], 4'b0010, 32'h00001100}) begin
            errors++;
            $display("FAIL partial_first: got %0d writes want 1 write %h", got_q.size(), {b[31:2], 4'b0010, 32'h00001100});
        end
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL partial_busy: busy_o got %b want 1 with buffered byte", busy_o);
        end
        flush_pulse();
        drain(100, "partial");
        checks++;
        if (got_q.size() != 2 || got_q[1] !== {b4[31:2], 4'b0100, 32'h00220000}) begin
            errors++;
            $display("FAIL partial_second: got %0d writes want 2, second %h", got_q.size(), {b4[31:2], 4'b0100, 32'h00220000});
        end
    endtask

    task automatic test_same_lane();
        bit ok;
        logic [31:0] b;
        b = 32'h0383C1D1;
        clear_state();
        send_byte(b, 8'hFF, ok);
        send_byte(b, 8'h00, ok);
        repeat (20) @(posedge clk_i);
        #1;
        checks++;
        if (got_q.size() != 1 || got_q[0] !== {b[31:2], 4'b0100, 32'h00FF0000}) begin
            errors++;
            $display("FAIL same_lane_first: got %0d writes want 1 write %h", got_q.size(), {b[31:2], 4'b0100, 32'h00FF0000});
        end
        flush_pulse();
        drain(100, "same_lane");
        checks++;
        if (got_q.size() != 2 || got_q[1] !== {b[31:2], 4'b0100, 32'h00000000}) begin
            errors++;
            $display("FAIL same_lane_second: got %0d writes want 2, second %h", got_q.size(), {b[31:2], 4'b0100, 32'h0});
        end
    endtask

    task automatic test_flush_with_byte();
        clear_state();
        byte_adr_i = 32'h1000_0003;
        byte_dat_i = 8'h5A;
        byte_stb_i = 1'b1;
        flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        checks++;
        if (byte_ack_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_byte_ack: ack got %b want 1", byte_ack_o);
        end
        @(posedge clk_i);
        #1;
        byte_stb_i = 1'b0;
        drain(100, "flush_byte");
        checks++;
        if (got_q.size() != 1 || got_q[0] !== {30'h04000000, 4'b0001, 32'h0000005A}) begin
            errors++;
            $display("FAIL flush_byte_write: got %0d writes want 1 write %h", got_q.size(), {30'h04000000, 4'b0001, 32'h0000005A});
        end
    endtask

    task automatic test_flush_empty();
        int hi;
        clear_state();
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_empty_pre: busy_o got %b want 0", busy_o);
        end
        flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        hi = 0;
        for (int i = 0; i < 6; i++) begin
            if (busy_o) hi++;
            @(posedge clk_i);
            #1;
        end
        checks++;
        if (hi != 1 || got_q.size() != 0) begin
            errors++;
            $display("FAIL flush_empty: busy cycles got %0d writes %0d want 1 and 0", hi, got_q.size());
        end
    endtask

    task automatic test_back_to_back_stall();
        int acc;
        int acc_at_rel;
        int got_at_rel;
        bit ok;
        acc = 0;
        acc_at_rel = -1;
        got_at_rel = -1;
        clear_state();
        ack_nowait = 1'b1;
        ack_block = 1'b1;
        fork
            begin
                repeat (50) @(posedge clk_i);
                #2;
                acc_at_rel = acc;
                got_at_rel = got_q.size();
                ack_block = 1'b0;
            end
            begin
                for (int i = 0; i < 24; i++) begin
                    send_byte(32'h2000_0000 + 32'(i), 8'($urandom), ok);
                    if (ok) acc++;
                end
            end
        join
        drain(300, "stall");
        checks++;
        if (acc_at_rel != 20 || got_at_rel != 0) begin
            errors++;
            $display("FAIL stall_hold: accepted %0d writes %0d while held want 20 and 0", acc_at_rel, got_at_rel);
        end
        checks++;
        if (got_q.size() != 6) begin
            errors++;
            $display("FAIL stall_count: got %0d writes want 6", got_q.size());
        end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL stall_write%0d: got %h want %h", i, i < got_q.size() ? got_q[i] : 66'h0, exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        logic [31:0] a;
        clear_state();
        ack_nowait = 1'b0;
        for (int it = 0; it < 120; it++) begin
            if ($urandom_range(0, 9) == 0) begin
                flush_pulse();
            end else begin
                a = 32'h4000_0000 + 32'($urandom_range(0, 11));
                send_byte(a, 8'($urandom), ok);
            end
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk_i);
                #1;
            end
        end
        flush_pulse();
        drain(3000, "random");
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL random_count: got %0d writes want %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL random_write%0d: got %h want %h", i, i < got_q.size() ? got_q[i] : 66'h0, exp_q[i]);
            end
        end
        ack_nowait = 1'b1;
    endtask

    initial begin
        apply_reset();
        test_reset();
        test_full_word();
        test_partial_flush();
        test_same_lane();
        test_flush_with_byte();
        test_flush_empty();
        test_back_to_back_stall();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
